word_uart_tx: RTL

WORD_UART_TX -- requirements
Module: word_uart_tx

---
 rtl/word_uart_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/word_uart_tx.sv
// Byte/word UART transmitter: 8N1 frames (optional even parity, 1-2 stop bits), one byte or WORD_BYTES bytes per request.
// Optional even parity bit: define WORD_UART_TX_PARITY_EN.
module word_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_mode_select,
  input  logic                    i_msb_first,
  input  logic [7:0]              i_byte,
  input  logic [WORD_BYTES*8-1:0] i_word,
  output logic                    o_serial,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [2:0]              main_state
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(WORD_BYTES + 1);
  localparam int unsigned DW = WORD_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [TW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [CW-1:0]   r_byte_cnt;
  logic            r_mode;
  logic            r_msb;
  logic [DW-1:0]   r_word;
  logic [7:0]      r_cur;

  logic            w_accept;
  logic            w_bit_end;
  logic            w_stop_end;
  logic            w_last;
  logic [CW-1:0]   w_nxt_cnt;
  logic [CW-1:0]   w_idx;
  logic [7:0]      w_first_byte;
  logic [7:0]      w_next_byte;
  logic            w_serial;
  logic            w_ready;
  logic            w_done;

  assign w_accept   = i_valid && o_ready;
  assign w_bit_end  = (r_clk_cnt == TW'(CLKS_PER_BIT - 1));
  assign w_stop_end = w_bit_end && (r_bit_cnt == 3'(STOP_BITS - 1));
  assign w_nxt_cnt  = r_byte_cnt + CW'(1);
  assign w_last     = (w_nxt_cnt == (r_mode ? CW'(WORD_BYTES) : CW'(1)));
  assign w_idx      = r_msb ? (CW'(WORD_BYTES - 1) - w_nxt_cnt) : w_nxt_cnt;
  assign w_next_byte  = 8'(r_word >> {w_idx, 3'b000});
  assign w_first_byte = i_mode_select ? (i_msb_first ? i_word[DW-1 -: 8] : i_word[7:0]) : i_byte;
  assign main_state   = r_state;

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = ST_START;
      ST_START: if (w_bit_end) w_next_state = ST_DATA;
      ST_DATA: begin
        if (w_bit_end && (r_bit_cnt == 3'd7)) begin
`ifdef WORD_UART_TX_PARITY_EN
          w_next_state = ST_PARITY;
`else
          w_next_state = ST_STOP;
`endif
        end
      end
`ifdef WORD_UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_end) w_next_state = ST_STOP;
`endif
      ST_STOP:  if (w_stop_end) w_next_state = w_last ? ST_DONE : ST_START;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    w_serial = 1'b1;
    w_done   = 1'b0;
    w_ready  = 1'b0;
    case (r_state)
      ST_IDLE:   w_ready  = !w_accept;
      ST_START:  w_serial = 1'b0;
      ST_DATA:   w_serial = r_cur[r_bit_cnt];
`ifdef WORD_UART_TX_PARITY_EN
      ST_PARITY: w_serial = ^r_cur;
`endif
      ST_DONE:   w_done   = 1'b1;
      default:   w_serial = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      o_serial <= 1'b1;
      o_ready  <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_serial <= w_serial;
      o_ready  <= w_ready;
      o_busy   <= !w_ready;
      o_done   <= w_done;
    end
  end

  // Bit timer, bit counter and byte counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE || r_state == ST_DONE || w_bit_end) r_clk_cnt <= '0;
      else                                                       r_clk_cnt <= r_clk_cnt + TW'(1);

      if (r_state == ST_DATA && w_bit_end)   r_bit_cnt <= r_bit_cnt + 3'd1;
      else if (r_state == ST_STOP && w_bit_end)
        r_bit_cnt <= w_stop_end ? 3'd0 : r_bit_cnt + 3'd1;

      if (r_state == ST_IDLE && w_accept)      r_byte_cnt <= '0;
      else if (r_state == ST_STOP && w_stop_end) r_byte_cnt <= w_nxt_cnt;
    end
  end

  // Payload capture; no reset needed
  always_ff @(posedge clock) begin
    if (r_state == ST_IDLE && w_accept) begin
      r_mode <= i_mode_select;
      r_msb  <= i_msb_first;
      r_word <= i_mode_select ? i_word : DW'(i_byte);
      r_cur  <= w_first_byte;
    end else if (r_state == ST_STOP && w_stop_end && !w_last) begin
      r_cur  <= w_next_byte;
    end
  end

endmodule
